// File: rtl/cmp_pkg.sv
// Shared compare-result encoding used by the bit-slice cascade and the comparator top.
package cmp_pkg;
  typedef logic [1:0] cmp_res_t;

  localparam cmp_res_t CMP_EQ = 2'b00;
  localparam cmp_res_t CMP_GT = 2'b01;
  localparam cmp_res_t CMP_LT = 2'b10;
endpackage

// File: rtl/cmp_bit_slice.sv
// One stage of the MSB-first compare cascade: an upstream decision wins, otherwise this bit pair decides.
module cmp_bit_slice
  import cmp_pkg::*;
(
  input  logic     a,
  input  logic     b,
  input  cmp_res_t up,
  output cmp_res_t res
);

  always_comb begin
    res = CMP_EQ;
    if (up != CMP_EQ)   res = up;
    else if (a && !b)   res = CMP_GT;
    else if (!a && b)   res = CMP_LT;
  end

endmodule

// File: rtl/comparator.sv
// Registered magnitude comparator: bit-slice cascade, optional two's-complement MSB fix-up, one-cycle latency.
module comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter bit SIGNED_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  // chain[WIDTH] seeds the cascade; chain[0] is the full-word unsigned result
  cmp_res_t chain [WIDTH:0];
  cmp_res_t res;

  assign chain[WIDTH] = CMP_EQ;

  for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_slice
    cmp_bit_slice u_slice (
      .a   (A[i]),
      .b   (B[i]),
      .up  (chain[i+1]),
      .res (chain[i])
    );
  end

  // Differing sign bits: the operand with the sign set is smaller, the opposite of the unsigned verdict
  always_comb begin
    res = chain[0];
    if (SIGNED_MODE && (A[WIDTH-1] != B[WIDTH-1]))
      res = A[WIDTH-1] ? CMP_LT : CMP_GT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      gt        <= 1'b0;
      lt        <= 1'b0;
      eq        <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        gt <= (res == CMP_GT);
        lt <= (res == CMP_LT);
        eq <= (res == CMP_EQ);
      end
    end
  end

endmodule

// File: tb/tb_comparator.sv
// Bench: WIDTH=2 unsigned/signed, WIDTH=8 and WIDTH=1 instances checked against an arithmetic reference model.
module tb_comparator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] a2, b2;
  logic [7:0] a8, b8;
  logic [0:0] a1, b1;

  logic ov_u2, gt_u2, lt_u2, eq_u2;
  logic ov_s2, gt_s2, lt_s2, eq_s2;
  logic ov_u8, gt_u8, lt_u8, eq_u8;
  logic ov_u1, gt_u1, lt_u1, eq_u1;

  // model state {out_valid, gt, lt, eq}
  logic [3:0] m_u2, m_s2, m_u8, m_u1;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  comparator #(.WIDTH(2), .SIGNED_MODE(1'b0)) u_u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a2), .B(b2),
    .out_valid(ov_u2), .gt(gt_u2), .lt(lt_u2), .eq(eq_u2));
  comparator #(.WIDTH(2), .SIGNED_MODE(1'b1)) u_s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a2), .B(b2),
    .out_valid(ov_s2), .gt(gt_s2), .lt(lt_s2), .eq(eq_s2));
  comparator #(.WIDTH(8), .SIGNED_MODE(1'b0)) u_u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a8), .B(b8),
    .out_valid(ov_u8), .gt(gt_u8), .lt(lt_u8), .eq(eq_u8));
  comparator #(.WIDTH(1), .SIGNED_MODE(1'b0)) u_u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a1), .B(b1),
    .out_valid(ov_u1), .gt(gt_u1), .lt(lt_u1), .eq(eq_u1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: interpret operands as integers (sign-adjusted when signed) and compare arithmetically
  function automatic logic [2:0] ref_cmp(input int w, input bit sgn,
                                         input logic [31:0] a, input logic [31:0] b);
    longint va, vb;
    va = longint'(a);
    vb = longint'(b);
    if (sgn && a[w-1]) va = va - (longint'(1) << w);
    if (sgn && b[w-1]) vb = vb - (longint'(1) << w);
    return {va > vb, va < vb, va == vb};
  endfunction

  function automatic logic [3:0] next_state(input logic [3:0] cur, input logic [2:0] r);
    return in_valid ? {1'b1, r} : {1'b0, cur[2:0]};
  endfunction

  task automatic check_all(input string tag);
    chk($sformatf("%s_u2", tag), {ov_u2, gt_u2, lt_u2, eq_u2}, m_u2);
    chk($sformatf("%s_s2", tag), {ov_s2, gt_s2, lt_s2, eq_s2}, m_s2);
    chk($sformatf("%s_u8", tag), {ov_u8, gt_u8, lt_u8, eq_u8}, m_u8);
    chk($sformatf("%s_u1", tag), {ov_u1, gt_u1, lt_u1, eq_u1}, m_u1);
    if (ov_u2) chk($sformatf("%s_onehot_u2", tag), $countones({gt_u2, lt_u2, eq_u2}), 1);
    if (ov_s2) chk($sformatf("%s_onehot_s2", tag), $countones({gt_s2, lt_s2, eq_s2}), 1);
  endtask

  task automatic model_reset();
    m_u2 = '0; m_s2 = '0; m_u8 = '0; m_u1 = '0;
  endtask

  // Advance one clock: update the model from inputs present at the edge, then sample #1 later
  task automatic step(input string tag);
    @(posedge clk);
    if (rst_n) begin
      m_u2 = next_state(m_u2, ref_cmp(2, 1'b0, 32'(a2), 32'(b2)));
      m_s2 = next_state(m_s2, ref_cmp(2, 1'b1, 32'(a2), 32'(b2)));
      m_u8 = next_state(m_u8, ref_cmp(8, 1'b0, 32'(a8), 32'(b8)));
      m_u1 = next_state(m_u1, ref_cmp(1, 1'b0, 32'(a1), 32'(b1)));
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic v, input logic [1:0] a, input logic [1:0] b,
                       input logic [7:0] x, input logic [7:0] y);
    in_valid = v;
    a2 = a; b2 = b; a8 = x; b8 = y;
    a1 = 1'($urandom_range(0, 1));
    b1 = 1'($urandom_range(0, 1));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 2'd0, 8'd0, 8'd0);
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // exhaustive WIDTH=2 space on back-to-back beats
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 2'(i >> 2), 2'(i), 8'($urandom), 8'($urandom));
      step($sformatf("exh%0d", i));
      if (i == 1)  chk("exh_00v01_lt", lt_u2, 1);
      if (i == 9)  chk("exh_10v01_gt", gt_u2, 1);
      if (i == 15) chk("exh_11v11_eq", eq_u2, 1);
      if (i == 3)  chk("allzero_v_allone_signed_gt", gt_s2, 1);
    end

    // hold: flags stay put while in_valid is low and operands change
    drive(1'b1, 2'b10, 2'b00, 8'h00, 8'h00);
    step("hold_load");
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'b00, 2'b11, 8'($urandom), 8'($urandom));
      step($sformatf("hold%0d", i));
      chk("hold_gt", {ov_u2, gt_u2, lt_u2, eq_u2}, 4'b0100);
    end

    // signed WIDTH=2 directed
    drive(1'b1, 2'b11, 2'b01, 8'hFF, 8'h00);
    step("sgn_m1_p1");
    chk("sgn_m1vp1_lt", lt_s2, 1);
    chk("u8_ffv00_gt", gt_u8, 1);
    drive(1'b1, 2'b10, 2'b11, 8'h80, 8'h7F);
    step("sgn_m2_m1");
    chk("sgn_m2vm1_lt", lt_s2, 1);
    chk("u8_80v7f_gt", gt_u8, 1);
    drive(1'b1, 2'b01, 2'b10, 8'h00, 8'h00);
    step("sgn_p1_m2");
    chk("sgn_p1vm2_gt", gt_s2, 1);
    chk("u8_00v00_eq", eq_u8, 1);
    drive(1'b1, 2'b11, 2'b11, 8'hFF, 8'hFF);
    step("max_eq");

    // reset asserted mid-stream discards the pending beat
    drive(1'b1, 2'b01, 2'b00, 8'h12, 8'h34);
    step("pre_rst");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("mid_rst");
    #2;
    rst_n = 1'b1;
    drive(1'b1, 2'b01, 2'b01, 8'h55, 8'h55);
    step("post_rst");
    chk("post_rst_eq", {ov_u2, gt_u2, lt_u2, eq_u2}, 4'b1001);

    // randomized traffic with sporadic valid gaps
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 2'($urandom),
            8'($urandom), (i % 5 == 0) ? a8 : 8'($urandom));
      if (i % 5 == 0) b8 = a8;
      step($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/comparator.md
Name: comparator

Overview:
Registered magnitude comparator for two unsigned WIDTH-bit operands A and B.
- Produces mutually exclusive one-hot flags gt / lt / eq, registered one clock after a valid input.
- Sits on a datapath as a small compare stage; the default WIDTH=2 covers the full 4x4 exhaustive operand space.
- Combinational compare is built as an MSB-first bit-slice cascade.

Parameters:
- WIDTH, default 2: operand width in bits (legal range 1..32).
- SIGNED_MODE, default 0: 0 = unsigned compare; 1 = two's-complement compare (MSB is the sign bit).

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  reset, asynchronous assert, active-low; release is synchronised externally.
- in_valid  input  1  A/B are valid this cycle; sampled on the rising edge of clk.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- out_valid  output  1  flags below reflect the most recently accepted A/B.
- gt  output  1  A > B.
- lt  output  1  A < B.
- eq  output  1  A == B.

Behaviour:
- Reset, asynchronous on rst_n=0: out_valid=0, gt=0, lt=0, eq=0 immediately, independent of clk. Outputs stay in this state while rst_n is low.
- Latency: 1 cycle. On a rising edge with in_valid=1, the next state is the comparison of the A and B values present at that edge; out_valid=1 after that edge.
- If in_valid=0 at an edge: out_valid goes to 0, and gt/lt/eq hold their last values.
- No backpressure: every valid beat is accepted; back-to-back valid inputs give back-to-back results.
- Invariant: whenever out_valid=1, exactly one of gt/lt/eq is 1. After reset and before the first valid beat, all three are 0.
- Unsigned mode: plain binary magnitude compare over the WIDTH bits; no extension or truncation.
- Signed mode: if the MSBs differ, the operand with MSB=1 is smaller; otherwise use the unsigned compare of the full word.
- Cascade: scan from the MSB downward. The first differing bit decides gt/lt; if no bit differs, eq=1.
- Boundaries:
  - WIDTH=1 supported.
  - All-zeros vs all-ones gives lt in unsigned mode and gt in signed mode.
  - Equal operands at the maximum value give eq.
- X-propagation: X on A/B while in_valid=1 may yield X flags. X while in_valid=0 must not disturb the held flags.
- Reset asserted mid-stream: the pending result is discarded and out_valid=0. The first valid beat after release behaves normally.

Decomposition:
- Shared package cmp_pkg:
  - localparam encodings for a 2-bit compare result: CMP_EQ=2'b00, CMP_GT=2'b01, CMP_LT=2'b10.
  - A typedef cmp_res_t for that result.
- One sub-module, cmp_bit_slice: combinational, one bit pair plus the upstream cmp_res_t in, cmp_res_t out. If upstream is not EQ, pass it through; otherwise derive the result from this bit pair.
- The top instantiates WIDTH slices MSB-first, applies the signed-mode MSB fix-up, then registers the result.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> out_valid=0, gt=lt=eq=0 immediately, without waiting for a clk edge.
- Exhaustive WIDTH=2 unsigned: all 16 A/B pairs, 00/00 through 11/11, with in_valid=1 on consecutive cycles. Each result appears one cycle later:
  - 00 vs 01 -> lt=1
  - 10 vs 01 -> gt=1
  - 11 vs 11 -> eq=1
  - exactly one flag high on every result.
- Hold: apply A=10, B=00 valid, then in_valid=0 for 3 cycles with A/B changed to 00/11 -> out_valid=0, gt stays 1, lt and eq stay 0.
- Signed mode, WIDTH=2: A=11 (-1) vs B=01 (+1) -> lt=1; A=10 (-2) vs B=11 (-1) -> lt=1; A=01 vs B=10 -> gt=1.
- Reset mid-stream: valid beat A=01, B=00, then rst_n low before the next edge -> out_valid=0 and all flags 0. After release, A=01, B=01 valid -> eq=1 one cycle later.
- WIDTH=8 unsigned: 0xFF vs 0x00 -> gt; 0x80 vs 0x7F -> gt; 0x00 vs 0x00 -> eq.
